valvula_multicanal: RTL and testbench

- N-channel registered valve controller and the parametrised successor of the single-channel combinational valve block.
- Each channel selects a manual or automatic request, as before, and drives one valve-open output.
- Adds per-channel minimum open/closed dwell times (anti-chatter), an automatic-mode maximum-open timeout with latched fault, and a shared tick-based time base.
- Sits between the level-control FSM / operator panel and the valve driver pins.

---
 rtl/valvula_multicanal.sv | 63 ++++++
 tb/tb_valvula_multicanal.sv | 135 +++++++++++++
 2 files changed

// File: rtl/valvula_multicanal.sv
// valvula_multicanal: N independent registered valve channels with dwell times, auto-mode open timeout and latched fault
module valvula_multicanal #(
  parameter int N_CANAIS      = 4,
  parameter int T_MIN_ABERTA  = 16,
  parameter int T_MIN_FECHADA = 16,
  parameter int T_MAX_ABERTA  = 1024
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  tick,
  input  logic [N_CANAIS-1:0]   manual,
  input  logic [N_CANAIS-1:0]   abre_manual,
  input  logic [N_CANAIS-1:0]   abre_auto,
  input  logic [N_CANAIS-1:0]   fecha_auto,
  input  logic [N_CANAIS-1:0]   limpa_falha,
  output logic [N_CANAIS-1:0]   abre_valvula,
  output logic [N_CANAIS-1:0]   falha,
  output logic [2*N_CANAIS-1:0] db_estado,
  output logic [N_CANAIS-1:0]   db_pedido
);
  localparam int T_TOPO = (T_MAX_ABERTA > T_MIN_FECHADA) ? T_MAX_ABERTA : T_MIN_FECHADA;
  localparam int CW = $clog2(T_TOPO + 1);
  localparam logic [CW-1:0] C_MIN_A = CW'(T_MIN_ABERTA);
  localparam logic [CW-1:0] C_MIN_F = CW'(T_MIN_FECHADA);
  localparam logic [CW-1:0] C_MAX_A = CW'(T_MAX_ABERTA);
  typedef enum logic [1:0] {FECHADA = 2'b00, ABERTA = 2'b01, FALHA = 2'b10, INVALIDO = 2'b11} estado_t;
  for (genvar c = 0; c < N_CANAIS; c++) begin : g_canal
    estado_t       r_estado, w_prox;
    logic [CW-1:0] r_cnt;
    logic          r_req, w_req;
    always_comb begin
      w_prox = r_estado;
      case (r_estado)
        FECHADA: w_prox = (r_req && r_cnt >= C_MIN_F) ? ABERTA : FECHADA;
        // timeout has priority over a normal close on the same edge
        ABERTA:  w_prox = (!manual[c] && r_cnt >= C_MAX_A) ? FALHA :
                          (!r_req && r_cnt >= C_MIN_A) ? FECHADA : ABERTA;
        FALHA:   w_prox = limpa_falha[c] ? FECHADA : FALHA;
        default: w_prox = FECHADA;
      endcase
    end
    assign w_req = (r_estado == FALHA && limpa_falha[c]) ? 1'b0 :
                   manual[c]     ? abre_manual[c] :
                   abre_auto[c]  ? 1'b1 :
                   fecha_auto[c] ? 1'b0 : r_req;
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        r_estado <= FECHADA;
        r_cnt    <= '0;
        r_req    <= 1'b0;
      end else begin
        r_estado <= w_prox;
        r_req    <= w_req;
        r_cnt    <= (w_prox != r_estado) ? '0 :
                    (tick && r_cnt != '1) ? r_cnt + CW'(1) : r_cnt;
      end
    end
    assign abre_valvula[c]    = (r_estado == ABERTA);
    assign falha[c]           = (r_estado == FALHA);
    assign db_estado[2*c +: 2] = r_estado;
    assign db_pedido[c]       = r_req;
  end
endmodule

// File: tb/tb_valvula_multicanal.sv
// tb_valvula_multicanal: table-driven check of a 2-channel valve controller plus reset and manual-mode sequences
module tb_valvula_multicanal;
  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       tick = 1'b0;
  logic [1:0] manual = '0, abre_manual = '0, abre_auto = '0, fecha_auto = '0, limpa_falha = '0;
  logic [1:0] abre_valvula, falha, db_pedido;
  logic [3:0] db_estado;
  int total = 0;
  int bad = 0;

  valvula_multicanal #(
    .N_CANAIS(2), .T_MIN_ABERTA(3), .T_MIN_FECHADA(2), .T_MAX_ABERTA(8)
  ) dut (
    .clock(clock), .reset_n(reset_n), .tick(tick), .manual(manual),
    .abre_manual(abre_manual), .abre_auto(abre_auto), .fecha_auto(fecha_auto),
    .limpa_falha(limpa_falha), .abre_valvula(abre_valvula), .falha(falha),
    .db_estado(db_estado), .db_pedido(db_pedido)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       tk;
    logic [1:0] man, am, aa, fa, lf;
    logic [1:0] ea, ef;
    logic [3:0] es;
    logic [1:0] ep;
  } vec_t;

  vec_t q[$];

  function automatic vec_t mk(input int tk, man, am, aa, fa, lf, ea, ef, es, ep);
    vec_t v;
    v.tk = 1'(tk); v.man = 2'(man); v.am = 2'(am); v.aa = 2'(aa); v.fa = 2'(fa); v.lf = 2'(lf);
    v.ea = 2'(ea); v.ef = 2'(ef); v.es = 4'(es); v.ep = 2'(ep);
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s step %0d: got=%h want=%h", nm, idx, act, exp);
    end
  endtask

  task automatic check_out(input string nm, input int idx, input vec_t v);
    chk({nm, ".abre"}, idx, {2'b00, abre_valvula}, {2'b00, v.ea});
    chk({nm, ".falha"}, idx, {2'b00, falha}, {2'b00, v.ef});
    chk({nm, ".estado"}, idx, db_estado, v.es);
    chk({nm, ".pedido"}, idx, {2'b00, db_pedido}, {2'b00, v.ep});
  endtask

  task automatic step(input string nm, input int idx, input vec_t v);
    tick = v.tk; manual = v.man; abre_manual = v.am; abre_auto = v.aa;
    fecha_auto = v.fa; limpa_falha = v.lf;
    @(posedge clock);
    #1;
    check_out(nm, idx, v);
  endtask

  task automatic reset_mid_cycle();
    #3 reset_n = 1'b0;
    #1 check_out("async_rst", 0, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tick = 1'b1; manual = '0; abre_manual = '0; abre_auto = '0; fecha_auto = '0; limpa_falha = '0;
    @(negedge clock) reset_n = 1'b1;
  endtask

  initial begin
    // auto open latency, normal close, tick freeze
    q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    q.push_back(mk(1, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    q.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0));
    for (int i = 0; i < 4; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    for (int i = 0; i < 3; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // auto timeout into fault, then clear
    q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 1, 1));
    for (int i = 0; i < 8; i++) q.push_back(mk(1, 0, 0, 1, 0, 0, 1, 0, 1, 1));
    q.push_back(mk(1, 0, 0, 1, 0, 0, 0, 1, 2, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 1, 0, 0, 0, 0));
    // open and close together: open wins; fault ignores manual open
    q.push_back(mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    for (int i = 0; i < 8; i++) q.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1));
    q.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 2, 1));
    q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 2, 1));
    q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 1, 2, 1));
    q.push_back(mk(1, 1, 1, 0, 0, 1, 0, 0, 0, 0));
    q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 1));
    q.push_back(mk(1, 1, 1, 0, 0, 0, 1, 0, 1, 1));

    #2;
    check_out("reset", 0, mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    @(negedge clock) reset_n = 1'b1;
    foreach (q[i]) step("tbl", i, q[i]);

    // asynchronous reset while ch0 is open, then reopen from zero
    reset_mid_cycle();
    step("reopen", 1, mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    step("reopen", 2, mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    step("reopen", 3, mk(1, 0, 0, 0, 0, 0, 1, 0, 1, 1));

    // manual mode on ch1: no timeout, close gated by minimum open time
    reset_mid_cycle();
    for (int k = 1; k <= 20; k++)
      step("man", k, mk(1, 2, 2, 0, 0, 0, (k >= 3) ? 2 : 0, 0, (k >= 3) ? 4 : 0, 2));
    step("man_drop", 1, mk(1, 2, 0, 0, 0, 0, 2, 0, 4, 0));
    step("man_drop", 2, mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));
    step("man_quick", 1, mk(1, 2, 2, 0, 0, 0, 0, 0, 0, 2));
    step("man_quick", 2, mk(1, 2, 2, 0, 0, 0, 0, 0, 0, 2));
    step("man_quick", 3, mk(1, 2, 2, 0, 0, 0, 2, 0, 4, 2));
    step("man_quick", 4, mk(1, 2, 0, 0, 0, 0, 2, 0, 4, 0));
    step("man_quick", 5, mk(1, 2, 0, 0, 0, 0, 2, 0, 4, 0));
    step("man_quick", 6, mk(1, 2, 0, 0, 0, 0, 2, 0, 4, 0));
    step("man_quick", 7, mk(1, 2, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
